life_cell_rule: RTL and testbench

//  Parametrised Life-like cellular automaton cell; successor to the fixed B3/S23 cell.

---
 rtl/life_cell_rule.sv | 95 +++++++++
 tb/tb_life_cell_rule.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/life_cell_rule.sv
// Life-like cellular automaton cell with a programmable birth/survive rule, age, change pulse and stability flag.
// Latency: state_d is combinational from neighbors; the other outputs update one cycle after ena/load.
// Backpressure: none; the grid controller paces generations with ena.
module life_cell_rule #(
    parameter int N_NEIGHBORS   = 8,
    parameter int AGE_W         = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ena,
    input  logic                   load,
    input  logic                   state_0,
    input  logic [N_NEIGHBORS-1:0] neighbors,
    input  logic                   rule_we,
    input  logic [N_NEIGHBORS:0]   birth_in,
    input  logic [N_NEIGHBORS:0]   survive_in,
    output logic                   state_d,
    output logic                   state_q,
    output logic [AGE_W-1:0]       age_q,
    output logic                   changed,
    output logic                   stable
);

    localparam int CW = $clog2(N_NEIGHBORS + 1);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam logic [SW-1:0]        STABLE_MAX  = SW'(STABLE_CYCLES);
    localparam logic [AGE_W-1:0]     AGE_MAX     = '1;
    // Conway B3/S23; bits beyond the neighbour range are simply dropped
    localparam logic [N_NEIGHBORS:0] BIRTH_RST   = (N_NEIGHBORS + 1)'(16'h0008);
    localparam logic [N_NEIGHBORS:0] SURVIVE_RST = (N_NEIGHBORS + 1)'(16'h000C);

    logic [N_NEIGHBORS:0] birth_r;
    logic [N_NEIGHBORS:0] survive_r;
    logic [CW-1:0]        count;
    logic [SW-1:0]        stab_cnt;
    logic [SW-1:0]        stab_nxt;

    always_comb begin
        count = '0;
        for (int i = 0; i < N_NEIGHBORS; i++) begin
            count = count + CW'(neighbors[i]);
        end
    end

    assign state_d = state_q ? survive_r[count] : birth_r[count];

    always_comb begin
        stab_nxt = '0;
        if (state_d == state_q) begin
            stab_nxt = (stab_cnt == STABLE_MAX) ? stab_cnt : stab_cnt + SW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            birth_r   <= BIRTH_RST;
            survive_r <= SURVIVE_RST;
        end else if (rule_we) begin
            birth_r   <= birth_in;
            survive_r <= survive_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= 1'b0;
            age_q    <= '0;
            changed  <= 1'b0;
            stable   <= 1'b0;
            stab_cnt <= '0;
        end else begin
            changed <= 1'b0;
            if (load) begin
                state_q  <= state_0;
                age_q    <= AGE_W'(state_0);
                stab_cnt <= '0;
                stable   <= 1'b0;
            end else if (ena) begin
                state_q  <= state_d;
                changed  <= state_d ^ state_q;
                stab_cnt <= stab_nxt;
                stable   <= (stab_nxt == STABLE_MAX);
                if (!state_d) begin
                    age_q <= '0;
                end else if (!state_q) begin
                    age_q <= AGE_W'(1);
                end else if (age_q != AGE_MAX) begin
                    age_q <= age_q + AGE_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_life_cell_rule.sv
// Directed bench for life_cell_rule: an 8-neighbour and a 6-neighbour instance, checked through an expectation queue.
module tb_life_cell_rule;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena, load, state_0, rule_we;
    logic [7:0] nb;
    logic [8:0] birth_in, survive_in;
    logic       state_d, state_q, changed, stable;
    logic [3:0] age_q;

    logic       ena6, load6, s06, we6;
    logic [5:0] nb6;
    logic [6:0] b6, s6;
    logic       d6, q6, ch6, st6;
    logic [3:0] age6;

    always #5 clk = ~clk;

    life_cell_rule #(.N_NEIGHBORS(8), .AGE_W(4), .STABLE_CYCLES(4)) u_dut8 (
        .clk(clk), .rst(rst), .ena(ena), .load(load), .state_0(state_0),
        .neighbors(nb), .rule_we(rule_we), .birth_in(birth_in), .survive_in(survive_in),
        .state_d(state_d), .state_q(state_q), .age_q(age_q), .changed(changed), .stable(stable)
    );

    life_cell_rule #(.N_NEIGHBORS(6), .AGE_W(4), .STABLE_CYCLES(4)) u_dut6 (
        .clk(clk), .rst(rst), .ena(ena6), .load(load6), .state_0(s06),
        .neighbors(nb6), .rule_we(we6), .birth_in(b6), .survive_in(s6),
        .state_d(d6), .state_q(q6), .age_q(age6), .changed(ch6), .stable(st6)
    );

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic expect_val(input string tag, input logic [7:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [7:0] obs);
        exp_t e;
        n_assert++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; ena = 0; load = 0; state_0 = 0; rule_we = 0;
        nb = '0; birth_in = '0; survive_in = '0;
        ena6 = 0; load6 = 0; s06 = 0; we6 = 0; nb6 = '0; b6 = '0; s6 = '0;
        #2;
        // reset state of both instances
        expect_val("rst_state_q", 0); expect_val("rst_age_q", 0); expect_val("rst_changed", 0);
        expect_val("rst_stable", 0); expect_val("rst_state_d", 0);
        expect_val("rst6_state_q", 0); expect_val("rst6_age_q", 0);
        chk(state_q); chk(age_q); chk(changed); chk(stable); chk(state_d); chk(q6); chk(age6);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // birth with three neighbours
        nb = 8'b0000_0111; ena = 1;
        #1;
        expect_val("t1_state_d", 1); chk(state_d);
        expect_val("t1_state_q", 1); expect_val("t1_age_q", 1);
        expect_val("t1_changed", 1); expect_val("t1_stable", 0);
        tick();
        chk(state_q); chk(age_q); chk(changed); chk(stable);

        // idle cycle: changed drops, state holds
        ena = 0;
        expect_val("hold_state_q", 1); expect_val("hold_age_q", 1); expect_val("hold_changed", 0);
        tick();
        chk(state_q); chk(age_q); chk(changed);

        load = 1; state_0 = 0;
        expect_val("load0_state_q", 0); expect_val("load0_age_q", 0);
        tick();
        chk(state_q); chk(age_q);
        load = 0;

        // rule write together with ena: step still uses B3
        rule_we = 1; birth_in = 9'h004; survive_in = 9'h000; ena = 1; nb = 8'h03;
        #1;
        expect_val("t2_state_d_oldrule", 0); chk(state_d);
        expect_val("t2_state_q_oldrule", 0); expect_val("t2_changed_oldrule", 0);
        tick();
        chk(state_q); chk(changed);
        rule_we = 0;
        #1;
        expect_val("t2_state_d_newrule", 1); chk(state_d);
        expect_val("t2_state_q_newrule", 1); expect_val("t2_age_newrule", 1);
        expect_val("t2_changed_newrule", 1);
        tick();
        chk(state_q); chk(age_q); chk(changed);

        ena = 0; rule_we = 1; birth_in = 9'h008; survive_in = 9'h00C;
        expect_val("rw_state_q", 1); expect_val("rw_age_q", 1); expect_val("rw_changed", 0);
        tick();
        chk(state_q); chk(age_q); chk(changed);
        rule_we = 0;

        // long survival: age saturates, stable after four unchanged steps
        ena = 1; nb = 8'h03;
        for (int k = 1; k <= 20; k++) begin
            expect_val($sformatf("t3_age_k%0d", k), 8'((1 + k > 15) ? 15 : 1 + k));
            expect_val($sformatf("t3_stable_k%0d", k), (k >= 4) ? 8'd1 : 8'd0);
            expect_val($sformatf("t3_changed_k%0d", k), 0);
            expect_val($sformatf("t3_state_q_k%0d", k), 1);
            tick();
            chk(age_q); chk(stable); chk(changed); chk(state_q);
        end

        // rule write leaves age and stable alone; new rule B0/S- kills anything
        ena = 0; rule_we = 1; birth_in = 9'h001; survive_in = 9'h000;
        expect_val("rw2_age_q", 15); expect_val("rw2_stable", 1); expect_val("rw2_state_q", 1);
        tick();
        chk(age_q); chk(stable); chk(state_q);
        rule_we = 0;

        // load wins over ena (ena alone would kill the cell here)
        load = 1; state_0 = 1; ena = 1; nb = 8'h00;
        expect_val("t4_state_q", 1); expect_val("t4_age_q", 1);
        expect_val("t4_stable", 0); expect_val("t4_changed", 0);
        tick();
        chk(state_q); chk(age_q); chk(stable); chk(changed);
        load = 0; ena = 0;

        rule_we = 1; birth_in = 9'h008; survive_in = 9'h00C;
        tick();
        rule_we = 0;
        ena = 1; nb = 8'h03;
        repeat (6) tick();
        ena = 0;
        expect_val("t5_pre_age_q", 7); expect_val("t5_pre_stable", 1);
        chk(age_q); chk(stable);
        rule_we = 1; birth_in = 9'h001; survive_in = 9'h000;
        tick();
        rule_we = 0;
        expect_val("t5_rw_age_q", 7); expect_val("t5_rw_stable", 1);
        chk(age_q); chk(stable);

        // asynchronous reset between edges
        #3;
        rst = 1;
        #1;
        expect_val("t5_state_q", 0); expect_val("t5_age_q", 0);
        expect_val("t5_changed", 0); expect_val("t5_stable", 0);
        chk(state_q); chk(age_q); chk(changed); chk(stable);
        nb = 8'h07;
        #1;
        expect_val("t5_birth3_restored", 1); chk(state_d);
        nb = 8'h00;
        #1;
        expect_val("t5_birth0_cleared", 0); chk(state_d);
        @(posedge clk);
        #1;
        rst = 0;

        load = 1; state_0 = 1;
        tick();
        load = 0;
        nb = 8'h03;
        #1;
        expect_val("t5_survive2", 1); chk(state_d);
        nb = 8'h0F;
        #1;
        expect_val("t5_die4", 0); chk(state_d);
        nb = 8'hFF;
        #1;
        expect_val("t5_die8", 0); chk(state_d);

        // hex grid instance
        we6 = 1; b6 = 7'b0000100; s6 = 7'b0001100; load6 = 1; s06 = 1;
        expect_val("t6_load_state_q", 1);
        tick();
        chk(q6);
        we6 = 0; load6 = 0; nb6 = 6'b111111;
        #1;
        expect_val("t6_state_d", 0); chk(d6);
        ena6 = 1;
        expect_val("t6_state_q", 0); expect_val("t6_changed", 1); expect_val("t6_age_q", 0);
        tick();
        chk(q6); chk(ch6); chk(age6);
        ena6 = 0; nb6 = 6'b000011;
        #1;
        expect_val("t6_birth2", 1); chk(d6);

        if (sb.size() != 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
